// File: rtl/path_oram_ctrl.sv
// -----------------------------------------------------------------------------
// path_oram_ctrl
//   Path-ORAM controller. The bucket tree, stash, position map and leaf-remap
//   LFSR are all held in registers. One oblivious read or write is served at a
//   time. Every access reads one full root-to-leaf path into the stash, serves
//   the request from the stash, then writes the same path back. The address and
//   the operation do not change which kind of work is done.
//
//   Optional feature macro: ORAM_STATS_EN. When it is defined, the access
//   counter and stash high-water ports are added.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   req_valid      request present
//   req_ready      controller idle; a request is accepted when valid & ready
//   req_write      0 = read, 1 = write
//   req_addr       logical block number (D bits)
//   req_wdata      write data (8*A bits, ignored on read)
//   rsp_valid      response present; held until rsp_ready
//   rsp_ready      consumer accepts the response
//   rsp_rdata      block value before this access
//   err_ovf        sticky stash-overflow flag
//   stat_accesses  (ORAM_STATS_EN) saturating count of accepted requests
//   stat_stash_max (ORAM_STATS_EN) peak stash occupancy, sampled after ACCESS
// -----------------------------------------------------------------------------
module path_oram_ctrl #(
  parameter int          D    = 4,
  parameter int          A    = 4,
  parameter int          L    = 4,
  parameter int          Z    = 4,
  parameter int          S    = 32,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [D-1:0]          req_addr,
  input  logic [8*A-1:0]        req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*A-1:0]        rsp_rdata,
  output logic                  err_ovf
`ifdef ORAM_STATS_EN
  ,
  output logic [31:0]           stat_accesses,
  output logic [$clog2(S+1)-1:0] stat_stash_max
`endif
);

  localparam int W  = 8 * A;
  localparam int NB = (2 ** (L + 1)) - 1;  // buckets in the tree
  localparam int NL = 2 ** L;              // leaves
  localparam int NA = 2 ** D;              // logical blocks
  localparam int LW = $clog2(L + 1);       // level counter width

  typedef struct packed {
    logic         valid;
    logic [D-1:0] addr;
    logic [L-1:0] leaf;
    logic [W-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_PATH,
    ACCESS,
    EVICT,
    WAIT_RSP
  } state_t;

  state_t        state;
  entry_t        tree  [NB*Z];   // bucket b, slot z lives at index b*Z + z
  entry_t        stash [S];
  logic [L-1:0]  posmap [NA];
  logic [15:0]   lfsr;
  logic [LW-1:0] level;
  logic          op_write;
  logic [D-1:0]  op_addr;
  logic [W-1:0]  op_wdata;
  logic [L-1:0]  leaf;
  logic [L-1:0]  new_leaf;
  logic          rsp_taken;

  // Next-state values produced by the path datapath
  entry_t        stash_nxt  [S];
  entry_t        bucket_nxt [Z];
  logic          ovf_set;
  logic [W-1:0]  old_data;
  logic [15:0]   lfsr_next;
  int            nb;             // first slot index of the current bucket

  // Heap-ordered bucket index on the path to lf at depth lvl, scaled to slots.
  function automatic int node_base(input int lvl, input logic [L-1:0] lf);
    int n;
    n = (1 << lvl) - 1 + (int'(lf) >> (L - lvl));
    return n * Z;
  endfunction

  // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1 (right shift, mask 0xB400)
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb nb = node_base(int'(level), leaf);

  // NOTE: every output of this block gets a default first so no latches form.
  always_comb begin
    int cnt;
    int hit_i;
    int free_i;
    int slot_free;
    stash_nxt = stash;
    for (int z = 0; z < Z; z++) bucket_nxt[z] = '0;
    ovf_set  = 1'b0;
    old_data = '0;
    cnt      = 0;
    hit_i    = -1;
    free_i   = -1;
    case (state)
      RD_PATH: begin
        // Each valid slot claims the lowest stash entry still free after the
        // slots before it; the bucket is left empty either way.
        for (int z = 0; z < Z; z++) begin
          if (tree[nb+z].valid) begin
            slot_free = -1;
            for (int s = 0; s < S; s++)
              if (slot_free < 0 && !stash_nxt[s].valid) slot_free = s;
            if (slot_free >= 0) stash_nxt[slot_free] = tree[nb+z];
            else                ovf_set = 1'b1;
          end
        end
      end
      ACCESS: begin
        for (int s = 0; s < S; s++) begin
          if (hit_i < 0 && stash[s].valid && stash[s].addr == op_addr) hit_i = s;
          if (free_i < 0 && !stash[s].valid) free_i = s;
        end
        if (hit_i >= 0) begin
          old_data               = stash[hit_i].data;
          stash_nxt[hit_i].leaf  = new_leaf;
          if (op_write) stash_nxt[hit_i].data = op_wdata;
        end else if (free_i >= 0) begin
          // Never-written blocks read as zero.
          stash_nxt[free_i] = {1'b1, op_addr, new_leaf, op_write ? op_wdata : W'(0)};
        end else begin
          ovf_set = 1'b1;
        end
      end
      EVICT: begin
        // A block may sit at this level only if its leaf shares the top
        // `level` bits with the path leaf; lowest stash index wins.
        for (int s = 0; s < S; s++) begin
          if (stash[s].valid && cnt < Z &&
              (int'(stash[s].leaf) >> (L - int'(level))) ==
              (int'(leaf) >> (L - int'(level)))) begin
            bucket_nxt[cnt]    = stash[s];
            stash_nxt[s].valid = 1'b0;
            cnt++;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tree, stash and position map are plain flops that must come
      // up in a defined state, so they are reset with everything else.
      for (int i = 0; i < NB*Z; i++) tree[i] <= '0;
      for (int i = 0; i < S; i++)    stash[i] <= '0;
      for (int i = 0; i < NA; i++)   posmap[i] <= L'(i % NL);
      state     <= IDLE;
      lfsr      <= SEED;
      level     <= '0;
      op_write  <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      leaf      <= '0;
      new_leaf  <= '0;
      rsp_taken <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_write  <= req_write;
            op_addr   <= req_addr;
            op_wdata  <= req_wdata;
            leaf      <= posmap[req_addr];
            lfsr      <= lfsr_next;
            new_leaf  <= lfsr_next[L-1:0];
            level     <= '0;
            req_ready <= 1'b0;
            state     <= RD_PATH;
          end
        end
        RD_PATH: begin
          stash   <= stash_nxt;
          for (int z = 0; z < Z; z++) tree[nb+z] <= bucket_nxt[z];
          err_ovf <= err_ovf | ovf_set;
          if (level == LW'(L)) state <= ACCESS;
          else                 level <= level + LW'(1);
        end
        ACCESS: begin
          stash            <= stash_nxt;
          err_ovf          <= err_ovf | ovf_set;
          posmap[op_addr]  <= new_leaf;
          rsp_rdata        <= old_data;
          rsp_valid        <= 1'b1;
          rsp_taken        <= 1'b0;
          level            <= LW'(L);
          state            <= EVICT;
        end
        EVICT: begin
          stash <= stash_nxt;
          for (int z = 0; z < Z; z++) tree[nb+z] <= bucket_nxt[z];
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_taken <= 1'b1;
          end
          if (level == '0) begin
            if (rsp_taken || (rsp_valid && rsp_ready)) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end else begin
            level <= level - LW'(1);
          end
        end
        WAIT_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ORAM_STATS_EN
  localparam int SW = $clog2(S + 1);
  logic [SW-1:0] occ;

  always_comb begin
    occ = '0;
    for (int s = 0; s < S; s++) occ = occ + SW'(stash[s].valid);
  end

  // On the first EVICT cycle the stash still holds its post-ACCESS contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_accesses  <= '0;
      stat_stash_max <= '0;
    end else begin
      if (state == IDLE && req_valid && stat_accesses != '1)
        stat_accesses <= stat_accesses + 32'd1;
      if (state == EVICT && level == LW'(L) && occ > stat_stash_max)
        stat_stash_max <= occ;
    end
  end
`endif

endmodule

// File: tb/tb_path_oram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_path_oram_ctrl
//   Self-checking bench for path_oram_ctrl. The reference is a flat array of
//   block values: a read returns the stored value and a write returns the old
//   value and then replaces it. The tree, stash and leaf mapping are never
//   modelled, because they must not be visible at the ports.
// -----------------------------------------------------------------------------
module tb_path_oram_ctrl;

  localparam int L = 4;
  localparam int S = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        err_ovf;
`ifdef ORAM_STATS_EN
  logic [31:0] stat_accesses;
  logic [5:0]  stat_stash_max;
`endif

  path_oram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .err_ovf   (err_ovf)
`ifdef ORAM_STATS_EN
    ,
    .stat_accesses  (stat_accesses),
    .stat_stash_max (stat_stash_max)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  logic [31:0] ref_mem [16];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [34];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    acc_count = 0;
  endtask

  // Waits (bounded) for req_ready at a falling edge.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_ready_wait", req_ready, 1);
  endtask

  // One full transaction. lat is the count of falling edges after the accept
  // edge up to and including the first one that shows rsp_valid high.
  task automatic do_access(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output int lat);
    int n;
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    acc_count++;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    n = 1;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    repeat (hold) @(negedge clk);
    rd = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Applies one access to the reference and returns the expected response.
  function automatic logic [31:0] model_access(input logic wr, input logic [3:0] addr,
                                               input logic [31:0] wd);
    logic [31:0] old;
    old = ref_mem[addr];
    if (wr) ref_mem[addr] = wd;
    return old;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    logic [31:0] held;
    int          lat;
    int          n;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;

    // Stimulus table: write 5, read it back, write every block, read all back.
    vecs[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 4'd5, 32'h0, 32'hDEADBEEF};
    for (int i = 0; i < 16; i++)
      vecs[2+i] = '{1'b1, 4'(i), i * 32'h01010101, (i == 5) ? 32'hDEADBEEF : 32'h0};
    for (int i = 0; i < 16; i++)
      vecs[18+i] = '{1'b0, 4'(15 - i), 32'h0, (15 - i) * 32'h01010101};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_err_ovf", err_ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Never-written block reads zero with fixed latency.
    do_access(1'b0, 4'd3, 32'h0, 0, rd, lat);
    exp = model_access(1'b0, 4'd3, 32'h0);
    check("t1_rdata", rd, exp);
    check("t1_latency", lat, L + 3);

    for (int i = 0; i < 34; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, i % 3, rd, lat);
      exp = model_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_model", i), rd, exp);
      if (i % 8 == 0) check($sformatf("vec%0d_latency", i), lat, L + 3);
    end
    check("t3_err_ovf", err_ovf, 0);

    // Consumer stalls: response must hold steady and no new request is taken.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    @(posedge clk);
    acc_count++;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp  = model_access(1'b0, 4'd5, 32'h0);
    held = rsp_rdata;
    check("t4_rdata", held, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold_valid_%0d", i), rsp_valid, 1);
      check($sformatf("t4_hold_rdata_%0d", i), rsp_rdata, exp);
      check($sformatf("t4_hold_ready_%0d", i), req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t4_req_ready_after", req_ready, 1);
    check("t4_rsp_valid_after", rsp_valid, 0);

    // Reset in the middle of a path read wipes the earlier write.
    do_access(1'b1, 4'd2, 32'h12345678, 1, rd, lat);
    exp = model_access(1'b1, 4'd2, 32'h12345678);
    check("t5_write_rdata", rd, exp);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_req_ready", req_ready, 1);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    check("t5_rst_rsp_rdata", rsp_rdata, 0);
    check("t5_rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    do_access(1'b0, 4'd2, 32'h0, 0, rd, lat);
    exp = model_access(1'b0, 4'd2, 32'h0);
    check("t5_read_after_rst", rd, exp);

    // Random traffic against the reference array, from a clean reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      wd   = $urandom;
      do_access(wr, addr, wd, $urandom_range(0, 8), rd, lat);
      exp = model_access(wr, addr, wd);
      check($sformatf("rand%0d_rdata", i), rd, exp);
      check($sformatf("rand%0d_latency", i), lat, L + 3);
    end
    check("t6_err_ovf", err_ovf, 0);
`ifdef ORAM_STATS_EN
    check("t6_stat_accesses", stat_accesses, acc_count);
    check("t6_stat_stash_max_bound", stat_stash_max <= S, 1);
    check("t6_stat_stash_max_nonzero", stat_stash_max != 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
